// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - control/status bundle between the PLL lock sequencer and its surroundings
interface pll_lock_sequencer_if;
  logic       enable;
  logic       pll_locked;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic       lost_lock;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  modport master (
    input  enable, pll_locked,
    output pll_rst, clk_ready, fault, lost_lock, retry_cnt, state
  );

  modport slave (
    output enable, pll_locked,
    input  pll_rst, clk_ready, fault, lost_lock, retry_cnt, state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset / lock-acquisition sequencer with timeout, retries and lock qualification
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABILIZE = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             locked_meta, locked_sync;
  logic             attempt_fail;
  logic             pll_rst_q, pll_rst_d;
  logic             clk_ready_q, clk_ready_d;
  logic             fault_q, fault_d;
  logic             lost_lock_q, lost_lock_d;

  // pll_locked comes straight from the PLL and is asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      locked_meta <= bus.pll_locked;
      locked_sync <= locked_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      lost_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      clk_ready_q <= clk_ready_d;
      fault_q     <= fault_d;
      lost_lock_q <= lost_lock_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    if (!bus.enable) begin
      state_d = S_IDLE;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_RESET;
        S_RESET:     if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        // a lock seen on the timeout cycle still counts as a lock
        S_WAIT_LOCK: begin
          if (locked_sync)                 state_d = S_STABILIZE;
          else if (cnt_q == TIMEOUT_LAST)  attempt_fail = 1'b1;
        end
        S_STABILIZE: begin
          if (!locked_sync)               attempt_fail = 1'b1;
          else if (cnt_q == STABLE_LAST)  state_d = S_RUN;
        end
        S_RUN:       if (!locked_sync) state_d = S_RESET;
        S_FAULT:     state_d = S_FAULT;
        default:     state_d = S_IDLE;
      endcase
      if (attempt_fail) begin
        if (retry_q == RETRY_MAX) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_RESET;
          retry_d = retry_q + 4'd1;
        end
      end
      if (state_d == S_RUN && state_q != S_RUN) retry_d = 4'd0;
    end
    // counter restarts on every state entry and saturates otherwise
    if (state_d != state_q)    cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    pll_rst_d   = !(state_d inside {S_WAIT_LOCK, S_STABILIZE, S_RUN});
    clk_ready_d = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
    lost_lock_d = bus.enable && (state_q == S_RUN) && !locked_sync;
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.clk_ready = clk_ready_q;
  assign bus.fault     = fault_q;
  assign bus.lost_lock = lost_lock_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule
